// File: rtl/commit_monitor.sv
// commit_monitor: watches the ROB commit port and keeps retired-instruction and cycle counters.
// It also runs a commit-stall watchdog and an optional retired-instruction limit, and it emits
// one-cycle report records for the bench printer and the finish logic.
// Optional feature macro: COMMIT_MON_IPC_EN adds window_instr_o, the number of instructions
// retired since the previous report.
module commit_monitor #(
  parameter int unsigned     COMMIT_WIDTH    = 6,
  parameter int unsigned     CNT_W           = 64,
  parameter int unsigned     STUCK_LIMIT     = 5000,
  parameter int unsigned     REPORT_INTERVAL = 10000,
  parameter longint unsigned MAX_INSTR       = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [COMMIT_WIDTH-1:0] commit_valid_i,
  input  logic                    commit_is_walk_i,
  output logic [CNT_W-1:0]        instr_count_o,
  output logic [CNT_W-1:0]        cycle_count_o,
  output logic [31:0]             stuck_timer_o,
  output logic [1:0]              state_o,
  output logic                    report_valid_o,
  output logic [1:0]              report_reason_o,
  output logic [CNT_W-1:0]        report_cycle_o,
  output logic [CNT_W-1:0]        report_instr_o
`ifdef COMMIT_MON_IPC_EN
  ,
  output logic [CNT_W-1:0]        window_instr_o
`endif
);

  localparam int unsigned EffW       = $clog2(COMMIT_WIDTH + 1);
  localparam logic [31:0] IvlReload  = 32'(REPORT_INTERVAL - 1);
  localparam logic [31:0] StuckLast  = 32'(STUCK_LIMIT - 1);
  localparam logic [1:0]  RsnPeriod  = 2'd0;
  localparam logic [1:0]  RsnStuck   = 2'd1;
  localparam logic [1:0]  RsnDone    = 2'd2;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StStuck = 2'd1,
    StDone  = 2'd2
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [31:0]      stuck_q, stuck_d;
  logic [31:0]      ivl_q;
  logic             rv_q;
  logic [1:0]       reason_q;
  logic [CNT_W-1:0] rcycle_q, rinstr_q;
`ifdef COMMIT_MON_IPC_EN
  logic [CNT_W-1:0] win_q, win_d, rwin_q;
`endif

  logic [EffW-1:0] eff;
  logic            has_commit, go_stuck, go_done, ivl_zero, report;

  // Popcount of the commit slots; a ROB walk retires nothing.
  always_comb begin
    eff = '0;
    if (!commit_is_walk_i) begin
      for (int i = 0; i < int'(COMMIT_WIDTH); i++) begin
        eff = eff + EffW'(commit_valid_i[i]);
      end
    end
  end

  // Next counter values and the transition and report decisions for a RUN cycle.
  always_comb begin
    has_commit = (eff != '0);
    instr_d    = instr_q + CNT_W'(eff);
    cycle_d    = cycle_q + CNT_W'(1);
    if (has_commit)            stuck_d = '0;
    else if (stuck_q == '1)    stuck_d = stuck_q;
    else                       stuck_d = stuck_q + 32'd1;
    go_stuck = !has_commit && (stuck_q == StuckLast);
    go_done  = (MAX_INSTR != 0) && has_commit && (instr_d >= CNT_W'(MAX_INSTR));
    ivl_zero = (ivl_q == '0);
    report   = go_stuck || go_done || ivl_zero;
`ifdef COMMIT_MON_IPC_EN
    win_d    = win_q + CNT_W'(eff);
`endif
  end

  // Single state register; counters only advance in RUN, and terminal states are sticky.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StRun;
      instr_q  <= '0;
      cycle_q  <= '0;
      stuck_q  <= '0;
      ivl_q    <= IvlReload;
      rv_q     <= 1'b0;
      reason_q <= RsnPeriod;
      rcycle_q <= '0;
      rinstr_q <= '0;
`ifdef COMMIT_MON_IPC_EN
      win_q    <= '0;
      rwin_q   <= '0;
`endif
    end else if (state_q == StRun) begin
      instr_q <= instr_d;
      cycle_q <= cycle_d;
      stuck_q <= stuck_d;
      ivl_q   <= ivl_zero ? IvlReload : ivl_q - 32'd1;
      rv_q    <= report;
      if (go_stuck)     state_q <= StStuck;
      else if (go_done) state_q <= StDone;
      // A terminal report takes precedence over a coinciding periodic one.
      if (report) begin
        reason_q <= go_stuck ? RsnStuck : (go_done ? RsnDone : RsnPeriod);
        rcycle_q <= cycle_d;
        rinstr_q <= instr_d;
      end
`ifdef COMMIT_MON_IPC_EN
      if (report) begin
        rwin_q <= win_d;
        win_q  <= '0;
      end else begin
        win_q  <= win_d;
      end
`endif
    end else begin
      rv_q <= 1'b0;
    end
  end

  assign instr_count_o   = instr_q;
  assign cycle_count_o   = cycle_q;
  assign stuck_timer_o   = stuck_q;
  assign state_o         = state_q;
  assign report_valid_o  = rv_q;
  assign report_reason_o = reason_q;
  assign report_cycle_o  = rcycle_q;
  assign report_instr_o  = rinstr_q;
`ifdef COMMIT_MON_IPC_EN
  assign window_instr_o  = rwin_q;
`endif

endmodule

// File: tb/tb_commit_monitor.sv
// Bench for commit_monitor: a directed vector table on a small-limit instance, plus directed and
// random traffic on a second instance that is checked against a cycle-level reference model.
module tb_commit_monitor;

  localparam int unsigned     A_S = 20;
  localparam int unsigned     A_R = 10;
  localparam longint unsigned A_M = 0;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Instance A: long stall limit, interval 10, no instruction limit.
  logic        a_rst = 1'b1;
  logic [5:0]  a_cv = '0;
  logic        a_walk = 1'b0;
  logic [63:0] a_instr, a_cycle, a_rcycle, a_rinstr;
  logic [31:0] a_stuck;
  logic [1:0]  a_state, a_reason;
  logic        a_rv;
`ifdef COMMIT_MON_IPC_EN
  logic [63:0] a_win;
`endif

  commit_monitor #(
    .COMMIT_WIDTH(6), .CNT_W(64), .STUCK_LIMIT(A_S), .REPORT_INTERVAL(A_R), .MAX_INSTR(A_M)
  ) dut_a (
    .clock(clock), .reset(a_rst), .commit_valid_i(a_cv), .commit_is_walk_i(a_walk),
    .instr_count_o(a_instr), .cycle_count_o(a_cycle), .stuck_timer_o(a_stuck),
    .state_o(a_state), .report_valid_o(a_rv), .report_reason_o(a_reason),
    .report_cycle_o(a_rcycle), .report_instr_o(a_rinstr)
`ifdef COMMIT_MON_IPC_EN
    , .window_instr_o(a_win)
`endif
  );

  // Instance B: stall limit 5, interval 5, instruction limit 7.
  logic        b_rst = 1'b1;
  logic [5:0]  b_cv = '0;
  logic        b_walk = 1'b0;
  logic [63:0] b_instr, b_cycle, b_rcycle, b_rinstr;
  logic [31:0] b_stuck;
  logic [1:0]  b_state, b_reason;
  logic        b_rv;
`ifdef COMMIT_MON_IPC_EN
  logic [63:0] b_win;
`endif

  commit_monitor #(
    .COMMIT_WIDTH(6), .CNT_W(64), .STUCK_LIMIT(5), .REPORT_INTERVAL(5), .MAX_INSTR(7)
  ) dut_b (
    .clock(clock), .reset(b_rst), .commit_valid_i(b_cv), .commit_is_walk_i(b_walk),
    .instr_count_o(b_instr), .cycle_count_o(b_cycle), .stuck_timer_o(b_stuck),
    .state_o(b_state), .report_valid_o(b_rv), .report_reason_o(b_reason),
    .report_cycle_o(b_rcycle), .report_instr_o(b_rinstr)
`ifdef COMMIT_MON_IPC_EN
    , .window_instr_o(b_win)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Directed vectors for instance B.
  typedef struct {
    logic            rst;
    logic [5:0]      cv;
    logic            walk;
    logic [1:0]      st;
    longint unsigned ins;
    longint unsigned cyc;
    int unsigned     stk;
    logic            rv;
    logic [1:0]      rsn;
    longint unsigned rcyc;
    longint unsigned rins;
  } vec_t;

  function automatic vec_t mk(logic rst, logic [5:0] cv, logic walk, logic [1:0] st,
                              longint unsigned ins, longint unsigned cyc, int unsigned stk,
                              logic rv, logic [1:0] rsn, longint unsigned rcyc,
                              longint unsigned rins);
    vec_t v;
    v.rst = rst; v.cv = cv; v.walk = walk; v.st = st; v.ins = ins; v.cyc = cyc; v.stk = stk;
    v.rv = rv; v.rsn = rsn; v.rcyc = rcyc; v.rins = rins;
    return v;
  endfunction

  // Reference model for instance A: tracks counters by arithmetic on spec-level quantities.
  int unsigned     m_state;
  longint unsigned m_instr, m_cycle, m_rcyc, m_rins, m_win, m_rwin;
  longint unsigned m_stuck;
  bit              m_rv;
  int unsigned     m_reason;

  task automatic model_step(input bit rst, input logic [5:0] cv, input bit walk);
    int unsigned e;
    bit term;
    if (rst) begin
      m_state = 0; m_instr = 0; m_cycle = 0; m_stuck = 0; m_rv = 0; m_reason = 0;
      m_rcyc = 0; m_rins = 0; m_win = 0; m_rwin = 0;
    end else begin
      m_rv = 0;
      if (m_state == 0) begin
        e = walk ? 0 : $countones(cv);
        m_cycle++;
        m_instr += e;
        m_win   += e;
        if (e != 0) m_stuck = 0;
        else if (m_stuck < 64'hffff_ffff) m_stuck++;
        term = 0;
        if (e == 0 && m_stuck == A_S) begin
          m_state = 1; m_reason = 1; term = 1;
        end else if (A_M != 0 && e != 0 && m_instr >= A_M) begin
          m_state = 2; m_reason = 2; term = 1;
        end
        if (term || (m_cycle % A_R) == 0) begin
          if (!term) m_reason = 0;
          m_rv = 1; m_rcyc = m_cycle; m_rins = m_instr; m_rwin = m_win; m_win = 0;
        end
      end
    end
  endtask

  task automatic cycle_a(input bit rst, input logic [5:0] cv, input bit walk);
    a_rst = rst; a_cv = cv; a_walk = walk;
    model_step(rst, cv, walk);
    @(posedge clock);
    @(negedge clock);
    chk("a_state", a_state, m_state);
    chk("a_instr", a_instr, m_instr);
    chk("a_cycle", a_cycle, m_cycle);
    chk("a_stuck", a_stuck, m_stuck);
    chk("a_rv", a_rv, m_rv);
    chk("a_reason", a_reason, m_reason);
    chk("a_rcycle", a_rcycle, m_rcyc);
    chk("a_rinstr", a_rinstr, m_rins);
`ifdef COMMIT_MON_IPC_EN
    chk("a_window", a_win, m_rwin);
`endif
  endtask

  initial begin
    vec_t tbl[$];
    int   idle;

    // Limit, stall (with coinciding periodic), reset from each terminal state, periodic, walk.
    tbl.push_back(mk(1, 6'd0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 6'd7,  0, 0, 3, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 6'd7,  0, 0, 6, 2, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 6'd7,  0, 2, 9, 3, 0, 1, 2, 3, 9));
    tbl.push_back(mk(0, 6'd7,  0, 2, 9, 3, 0, 0, 2, 3, 9));
    tbl.push_back(mk(0, 6'd0,  0, 2, 9, 3, 0, 0, 2, 3, 9));
    tbl.push_back(mk(1, 6'd0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 6'd0,  0, 0, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 6'd0,  0, 0, 0, 2, 2, 0, 0, 0, 0));
    tbl.push_back(mk(0, 6'd0,  0, 0, 0, 3, 3, 0, 0, 0, 0));
    tbl.push_back(mk(0, 6'd0,  0, 0, 0, 4, 4, 0, 0, 0, 0));
    tbl.push_back(mk(0, 6'd0,  0, 1, 0, 5, 5, 1, 1, 5, 0));
    tbl.push_back(mk(0, 6'd63, 0, 1, 0, 5, 5, 0, 1, 5, 0));
    tbl.push_back(mk(0, 6'd0,  0, 1, 0, 5, 5, 0, 1, 5, 0));
    tbl.push_back(mk(1, 6'd0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 6'd1,  0, 0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 6'd1,  0, 0, 2, 2, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 6'd1,  0, 0, 3, 3, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 6'd1,  0, 0, 4, 4, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 6'd1,  0, 0, 5, 5, 0, 1, 0, 5, 5));
    tbl.push_back(mk(0, 6'd0,  0, 0, 5, 6, 1, 0, 0, 5, 5));
    tbl.push_back(mk(0, 6'd63, 1, 0, 5, 7, 2, 0, 0, 5, 5));

    for (int i = 0; i < tbl.size(); i++) begin
      b_rst = tbl[i].rst; b_cv = tbl[i].cv; b_walk = tbl[i].walk;
      @(posedge clock);
      @(negedge clock);
      chk($sformatf("b%0d_state", i),  b_state,  tbl[i].st);
      chk($sformatf("b%0d_instr", i),  b_instr,  tbl[i].ins);
      chk($sformatf("b%0d_cycle", i),  b_cycle,  tbl[i].cyc);
      chk($sformatf("b%0d_stuck", i),  b_stuck,  tbl[i].stk);
      chk($sformatf("b%0d_rv", i),     b_rv,     tbl[i].rv);
      chk($sformatf("b%0d_reason", i), b_reason, tbl[i].rsn);
      chk($sformatf("b%0d_rcycle", i), b_rcycle, tbl[i].rcyc);
      chk($sformatf("b%0d_rinstr", i), b_rinstr, tbl[i].rins);
    end
    b_rst = 1'b1;

    // Instance A: two commits per cycle, reports at cycles 10 and 20.
    cycle_a(1, 6'd0, 0);
    for (int k = 1; k <= 20; k++) begin
      cycle_a(0, 6'b000011, 0);
      if (k == 10) begin
        chk("p1_rv", a_rv, 1); chk("p1_rcycle", a_rcycle, 10); chk("p1_rinstr", a_rinstr, 20);
      end
      if (k == 20) begin
        chk("p2_rv", a_rv, 1); chk("p2_rcycle", a_rcycle, 20); chk("p2_rinstr", a_rinstr, 40);
      end
    end
    // A ROB walk retires nothing even with all slots valid.
    for (int k = 0; k < 8; k++) cycle_a(0, 6'b111111, 1);
    chk("walk_instr", a_instr, 40);
    chk("walk_stuck", a_stuck, 8);

    // Random traffic with stall bursts, resets while stuck and occasional mid-run resets.
    cycle_a(1, 6'd0, 0);
    idle = 0;
    for (int k = 0; k < 3000; k++) begin
      bit rst;
      rst = (m_state != 0 && $urandom_range(0, 9) == 0) || ($urandom_range(0, 799) == 0);
      if (idle == 0 && $urandom_range(0, 39) == 0) idle = $urandom_range(1, 25);
      if (idle > 0) begin
        idle--;
        cycle_a(rst, 6'd0, 0);
      end else begin
        cycle_a(rst, 6'($urandom), $urandom_range(0, 7) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
